// File: rtl/multi_cycle_controller.sv
// Control FSM for the multi-cycle RV32I core. It sequences the shared-memory datapath
// and halts on illegal instructions or on memory that never answers.
module multi_cycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 0,
  parameter int unsigned ALUCTL_W    = 4
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic [6:0]          op,
  input  logic [2:0]          func3,
  input  logic [6:0]          func7,
  input  logic                Zero,
  input  logic                Lt,
  input  logic                MemReady,
  output logic                PCWrite,
  output logic                AdrSrc,
  output logic                IRWrite,
  output logic                MemWrite,
  output logic                RegWrite,
  output logic [1:0]          ResultSrc,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [2:0]          ImmSrc,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic                Halt,
  output logic [3:0]          State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    JAL      = 4'd9,
    JALR     = 4'd10,
    BRANCH   = 4'd11,
    LUI      = 4'd12,
    ERROR    = 4'd15
  } stateT;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_SLT  = 3'd5;
  localparam logic [2:0] ALU_SLTU = 3'd6;

  stateT       state, nextState;
  logic [31:0] waitCount, waitNext;
  logic        timeoutHit;
  logic [2:0]  f3Code, aluSel;
  logic        f3Ok, rLegal;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state     <= FETCH;
      waitCount <= '0;
    end else begin
      state     <= nextState;
      waitCount <= waitNext;
    end
  end

  // Shared func3 map for register and immediate ALU ops; shifts are not supported.
  always_comb begin
    f3Code = ALU_ADD;
    f3Ok   = 1'b1;
    case (func3)
      3'b000:  f3Code = ALU_ADD;
      3'b111:  f3Code = ALU_AND;
      3'b110:  f3Code = ALU_OR;
      3'b100:  f3Code = ALU_XOR;
      3'b010:  f3Code = ALU_SLT;
      3'b011:  f3Code = ALU_SLTU;
      default: f3Ok   = 1'b0;
    endcase
  end

  assign rLegal = ((func7 == 7'b0000000) && f3Ok) ||
                  ((func7 == 7'b0100000) && (func3 == 3'b000));

  // A ready cycle always wins over the timeout, so the limit only fires while still waiting.
  assign timeoutHit = (MEM_TIMEOUT != 0) && !MemReady && (waitCount == MEM_TIMEOUT - 1);

  always_comb begin
    waitNext = waitCount;
    if (nextState != state)
      waitNext = '0;
    else if ((state inside {FETCH, MEMREAD, MEMWRITE}) && !MemReady)
      waitNext = waitCount + 32'd1;
  end

  always_comb begin
    nextState = state;
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ImmSrc    = IMM_I;
    aluSel    = ALU_ADD;
    Halt      = 1'b0;
    case (state)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
        if (MemReady)        nextState = DECODE;
        else if (timeoutHit) nextState = ERROR;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
        case (op)
          OP_LOAD, OP_STORE: nextState = MEMADR;
          OP_R:              nextState = EXECR;
          OP_I:              nextState = EXECI;
          OP_BRANCH:         nextState = BRANCH;
          OP_JAL:            nextState = JAL;
          OP_JALR:           nextState = (func3 == 3'b000) ? JALR : ERROR;
          OP_LUI:            nextState = LUI;
          default:           nextState = ERROR;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
        if (func3 != 3'b010)    nextState = ERROR;
        else if (op == OP_STORE) nextState = MEMWRITE;
        else                     nextState = MEMREAD;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        if (MemReady)        nextState = MEMWB;
        else if (timeoutHit) nextState = ERROR;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        nextState = FETCH;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (MemReady)        nextState = FETCH;
        else if (timeoutHit) nextState = ERROR;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        if (rLegal) begin
          aluSel    = (func7 == 7'b0100000) ? ALU_SUB : f3Code;
          nextState = ALUWB;
        end else begin
          nextState = ERROR;
        end
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        if (f3Ok) begin
          aluSel    = f3Code;
          nextState = ALUWB;
        end else begin
          nextState = ERROR;
        end
      end
      ALUWB: begin
        RegWrite  = 1'b1;
        nextState = FETCH;
      end
      JALR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        nextState = JAL;
      end
      // The jump target already sits in ALUOut; the ALU forms the link value OldPC+4.
      JAL: begin
        PCWrite   = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        nextState = ALUWB;
      end
      BRANCH: begin
        ALUSrcA   = 2'b10;
        aluSel    = ALU_SUB;
        nextState = FETCH;
        case (func3)
          3'b000:  PCWrite   = Zero;
          3'b001:  PCWrite   = !Zero;
          3'b100:  PCWrite   = Lt;
          3'b101:  PCWrite   = !Lt;
          default: nextState = ERROR;
        endcase
      end
      LUI: begin
        ImmSrc    = IMM_U;
        ResultSrc = 2'b11;
        RegWrite  = 1'b1;
        nextState = FETCH;
      end
      ERROR: begin
        Halt      = 1'b1;
        nextState = ERROR;
      end
      default: nextState = ERROR;
    endcase

    // Keep the datapath quiet while reset is held, even mid-instruction.
    if (!Rst_n) begin
      PCWrite   = 1'b0;
      AdrSrc    = 1'b0;
      IRWrite   = 1'b0;
      MemWrite  = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ImmSrc    = IMM_I;
      aluSel    = ALU_ADD;
    end
  end

  assign ALUControl = ALUCTL_W'(aluSel);
  assign State      = state;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed bench for multi_cycle_controller: one instance waits forever on memory,
// a second one gives up after four idle cycles.
module tb_multi_cycle_controller;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  logic       Clk, Rst_n, Zero, Lt, MemReady;
  logic [6:0] op, func7;
  logic [2:0] func3;

  logic       pcWrite, adrSrc, irWrite, memWrite, regWrite, halt;
  logic [1:0] resultSrc, aluSrcA, aluSrcB;
  logic [2:0] immSrc;
  logic [3:0] aluControl, state;

  logic       toPcWrite, toAdrSrc, toIrWrite, toMemWrite, toRegWrite, toHalt;
  logic [1:0] toResultSrc, toAluSrcA, toAluSrcB;
  logic [2:0] toImmSrc;
  logic [3:0] toAluControl, toState;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [3:0] st;
    logic [3:0] alu;
    logic [1:0] srcB;
  } aluVecT;

  typedef struct packed {
    logic [2:0] f3;
    logic       z;
    logic       lt;
    logic       taken;
    logic [3:0] nxt;
  } brVecT;

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       hasMid;
    logic [3:0] mid;
  } illVecT;

  multi_cycle_controller #(.MEM_TIMEOUT(0), .ALUCTL_W(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .op(op), .func3(func3), .func7(func7),
    .Zero(Zero), .Lt(Lt), .MemReady(MemReady),
    .PCWrite(pcWrite), .AdrSrc(adrSrc), .IRWrite(irWrite), .MemWrite(memWrite),
    .RegWrite(regWrite), .ResultSrc(resultSrc), .ALUSrcA(aluSrcA), .ALUSrcB(aluSrcB),
    .ImmSrc(immSrc), .ALUControl(aluControl), .Halt(halt), .State(state)
  );

  multi_cycle_controller #(.MEM_TIMEOUT(4), .ALUCTL_W(4)) dutTimeout (
    .Clk(Clk), .Rst_n(Rst_n), .op(op), .func3(func3), .func7(func7),
    .Zero(Zero), .Lt(Lt), .MemReady(MemReady),
    .PCWrite(toPcWrite), .AdrSrc(toAdrSrc), .IRWrite(toIrWrite), .MemWrite(toMemWrite),
    .RegWrite(toRegWrite), .ResultSrc(toResultSrc), .ALUSrcA(toAluSrcA), .ALUSrcB(toAluSrcB),
    .ImmSrc(toImmSrc), .ALUControl(toAluControl), .Halt(toHalt), .State(toState)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Safety net so a wedged run still ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                               input logic z, input logic l, input logic ready);
    op = o; func3 = f3; func7 = f7; Zero = z; Lt = l; MemReady = ready;
    #1;
  endtask

  task automatic resetDut;
    Rst_n = 1'b0;
    step;
    Rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    $display("[TB] test_reset");
    Rst_n = 1'b0;
    applyStimulus(OP_LW, 3'b010, 7'd0, 1'b0, 1'b0, 1'b1);
    step;
    total++; if (state !== 4'd0) begin bad++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
    total++; if (halt !== 1'b0) begin bad++; $display("[TB] FAIL reset_halt: got %0d expected 0", halt); end
    total++; if ({irWrite, pcWrite} !== 2'b00) begin bad++; $display("[TB] FAIL reset_strobes: got %b expected 00", {irWrite, pcWrite}); end
    total++; if ({aluSrcB, resultSrc} !== 4'b0000) begin bad++; $display("[TB] FAIL reset_selects: got %b expected 0000", {aluSrcB, resultSrc}); end
    Rst_n = 1'b1;
    #1;
    step;
    total++; if (state !== 4'd1) begin bad++; $display("[TB] FAIL lw_decode: got %0d expected 1", state); end
    step;
    total++; if (state !== 4'd2 || immSrc !== 3'b000 || aluSrcA !== 2'b10) begin bad++; $display("[TB] FAIL lw_memadr: got st=%0d imm=%b a=%b expected st=2 imm=000 a=10", state, immSrc, aluSrcA); end
    step;
    total++; if (state !== 4'd3 || adrSrc !== 1'b1) begin bad++; $display("[TB] FAIL lw_memread: got st=%0d adr=%0d expected st=3 adr=1", state, adrSrc); end
    Rst_n = 1'b0;
    applyStimulus(OP_LW, 3'b010, 7'd0, 1'b0, 1'b0, 1'b0);
    total++; if (adrSrc !== 1'b0) begin bad++; $display("[TB] FAIL reset_mid_adrsrc: got %0d expected 0", adrSrc); end
    applyStimulus(OP_LW, 3'b010, 7'd0, 1'b0, 1'b0, 1'b1);
    step;
    total++; if (state !== 4'd0 || irWrite !== 1'b0 || pcWrite !== 1'b0) begin bad++; $display("[TB] FAIL reset_mid_cycle1: got st=%0d ir=%0d pc=%0d expected 0 0 0", state, irWrite, pcWrite); end
    step;
    total++; if (state !== 4'd0) begin bad++; $display("[TB] FAIL reset_mid_cycle2: got %0d expected 0", state); end
    Rst_n = 1'b1;
    #1;
    total++; if ({irWrite, pcWrite, resultSrc, aluSrcB} !== 6'b111010) begin bad++; $display("[TB] FAIL fetch_outputs: got %b expected 111010", {irWrite, pcWrite, resultSrc, aluSrcB}); end
    step;
    total++; if (state !== 4'd1) begin bad++; $display("[TB] FAIL reset_release_decode: got %0d expected 1", state); end
  endtask

  task automatic test_alu_ops;
    aluVecT v [11];
    $display("[TB] test_alu_ops");
    v = '{'{OP_R, 3'b000, 7'h00, 4'd6, 4'd0, 2'b00},
          '{OP_R, 3'b000, 7'h20, 4'd6, 4'd1, 2'b00},
          '{OP_R, 3'b111, 7'h00, 4'd6, 4'd2, 2'b00},
          '{OP_R, 3'b110, 7'h00, 4'd6, 4'd3, 2'b00},
          '{OP_R, 3'b100, 7'h00, 4'd6, 4'd4, 2'b00},
          '{OP_R, 3'b010, 7'h00, 4'd6, 4'd5, 2'b00},
          '{OP_R, 3'b011, 7'h00, 4'd6, 4'd6, 2'b00},
          '{OP_I, 3'b000, 7'h7f, 4'd7, 4'd0, 2'b01},
          '{OP_I, 3'b100, 7'h20, 4'd7, 4'd4, 2'b01},
          '{OP_I, 3'b011, 7'h00, 4'd7, 4'd6, 2'b01},
          '{OP_I, 3'b111, 7'h01, 4'd7, 4'd2, 2'b01}};
    resetDut;
    for (int i = 0; i < 11; i++) begin
      applyStimulus(v[i].op, v[i].f3, v[i].f7, 1'b0, 1'b0, 1'b1);
      total++; if (state !== 4'd0 || regWrite !== 1'b0) begin bad++; $display("[TB] FAIL alu%0d_fetch: got st=%0d rw=%0d expected st=0 rw=0", i, state, regWrite); end
      step;
      total++; if (state !== 4'd1 || regWrite !== 1'b0) begin bad++; $display("[TB] FAIL alu%0d_decode: got st=%0d rw=%0d expected st=1 rw=0", i, state, regWrite); end
      step;
      total++; if (state !== v[i].st || aluControl !== v[i].alu || aluSrcB !== v[i].srcB || aluSrcA !== 2'b10 || regWrite !== 1'b0)
        begin bad++; $display("[TB] FAIL alu%0d_exec: got st=%0d alu=%0d b=%b a=%b rw=%0d expected st=%0d alu=%0d b=%b a=10 rw=0", i, state, aluControl, aluSrcB, aluSrcA, regWrite, v[i].st, v[i].alu, v[i].srcB); end
      step;
      total++; if (state !== 4'd8 || regWrite !== 1'b1 || resultSrc !== 2'b00) begin bad++; $display("[TB] FAIL alu%0d_wb: got st=%0d rw=%0d rs=%b expected st=8 rw=1 rs=00", i, state, regWrite, resultSrc); end
      step;
    end
    total++; if (state !== 4'd0) begin bad++; $display("[TB] FAIL alu_last_fetch: got %0d expected 0", state); end
  endtask

  task automatic test_branch;
    brVecT v [8];
    $display("[TB] test_branch");
    v = '{'{3'b000, 1'b1, 1'b0, 1'b1, 4'd0},
          '{3'b000, 1'b0, 1'b0, 1'b0, 4'd0},
          '{3'b001, 1'b0, 1'b0, 1'b1, 4'd0},
          '{3'b001, 1'b1, 1'b0, 1'b0, 4'd0},
          '{3'b100, 1'b0, 1'b1, 1'b1, 4'd0},
          '{3'b101, 1'b0, 1'b1, 1'b0, 4'd0},
          '{3'b101, 1'b0, 1'b0, 1'b1, 4'd0},
          '{3'b010, 1'b1, 1'b1, 1'b0, 4'd15}};
    resetDut;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(OP_BR, v[i].f3, 7'd0, v[i].z, v[i].lt, 1'b1);
      step;
      total++; if (state !== 4'd1 || immSrc !== 3'b010) begin bad++; $display("[TB] FAIL br%0d_decode: got st=%0d imm=%b expected st=1 imm=010", i, state, immSrc); end
      step;
      total++; if (state !== 4'd11 || aluControl !== 4'd1 || pcWrite !== v[i].taken || aluSrcA !== 2'b10 || aluSrcB !== 2'b00)
        begin bad++; $display("[TB] FAIL br%0d_branch: got st=%0d alu=%0d pc=%0d a=%b b=%b expected st=11 alu=1 pc=%0d a=10 b=00", i, state, aluControl, pcWrite, aluSrcA, aluSrcB, v[i].taken); end
      step;
      total++; if (state !== v[i].nxt) begin bad++; $display("[TB] FAIL br%0d_next: got %0d expected %0d", i, state, v[i].nxt); end
    end
  endtask

  task automatic test_mem_wait;
    $display("[TB] test_mem_wait");
    resetDut;
    applyStimulus(OP_LW, 3'b010, 7'd0, 1'b0, 1'b0, 1'b1);
    step; step; step;
    total++; if (state !== 4'd3 || toState !== 4'd3) begin bad++; $display("[TB] FAIL lw_enter_memread: got %0d/%0d expected 3/3", state, toState); end
    applyStimulus(OP_LW, 3'b010, 7'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step;
      total++; if (state !== 4'd3 || adrSrc !== 1'b1 || toState !== 4'd3) begin bad++; $display("[TB] FAIL lw_wait%0d: got st=%0d adr=%0d to=%0d expected 3 1 3", i, state, adrSrc, toState); end
    end
    applyStimulus(OP_LW, 3'b010, 7'd0, 1'b0, 1'b0, 1'b1);
    step;
    total++; if (state !== 4'd4 || resultSrc !== 2'b01 || regWrite !== 1'b1) begin bad++; $display("[TB] FAIL lw_memwb: got st=%0d rs=%b rw=%0d expected st=4 rs=01 rw=1", state, resultSrc, regWrite); end
    total++; if (toState !== 4'd4) begin bad++; $display("[TB] FAIL lw_ready_wins: got %0d expected 4", toState); end
    step;
    total++; if (state !== 4'd0) begin bad++; $display("[TB] FAIL lw_back_fetch: got %0d expected 0", state); end
    applyStimulus(OP_SW, 3'b010, 7'd0, 1'b0, 1'b0, 1'b1);
    step; step;
    total++; if (state !== 4'd2 || immSrc !== 3'b001) begin bad++; $display("[TB] FAIL sw_memadr: got st=%0d imm=%b expected st=2 imm=001", state, immSrc); end
    step;
    total++; if (state !== 4'd5 || memWrite !== 1'b1 || adrSrc !== 1'b1) begin bad++; $display("[TB] FAIL sw_memwrite: got st=%0d mw=%0d adr=%0d expected 5 1 1", state, memWrite, adrSrc); end
    step;
    total++; if (state !== 4'd0 || memWrite !== 1'b0) begin bad++; $display("[TB] FAIL sw_done: got st=%0d mw=%0d expected 0 0", state, memWrite); end
  endtask

  task automatic test_timeout;
    $display("[TB] test_timeout");
    resetDut;
    applyStimulus(OP_SW, 3'b010, 7'd0, 1'b0, 1'b0, 1'b1);
    step; step; step;
    applyStimulus(OP_SW, 3'b010, 7'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      total++; if (toState !== 4'd5 || toMemWrite !== 1'b1) begin bad++; $display("[TB] FAIL sw_to_wait%0d: got st=%0d mw=%0d expected 5 1", i, toState, toMemWrite); end
      step;
    end
    total++; if (toState !== 4'd15 || toHalt !== 1'b1 || toMemWrite !== 1'b0) begin bad++; $display("[TB] FAIL sw_to_error: got st=%0d halt=%0d mw=%0d expected 15 1 0", toState, toHalt, toMemWrite); end
    total++; if (state !== 4'd5 || halt !== 1'b0) begin bad++; $display("[TB] FAIL sw_no_limit: got st=%0d halt=%0d expected 5 0", state, halt); end
    resetDut;
    applyStimulus(OP_R, 3'b000, 7'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      total++; if (toState !== 4'd0 || toIrWrite !== 1'b0) begin bad++; $display("[TB] FAIL fetch_to_wait%0d: got st=%0d ir=%0d expected 0 0", i, toState, toIrWrite); end
      step;
    end
    total++; if (toState !== 4'd15 || state !== 4'd0) begin bad++; $display("[TB] FAIL fetch_to_error: got %0d/%0d expected 15/0", toState, state); end
  endtask

  task automatic test_illegal;
    illVecT v [5];
    $display("[TB] test_illegal");
    resetDut;
    applyStimulus(7'b1111111, 3'b000, 7'd0, 1'b0, 1'b0, 1'b1);
    step; step;
    total++; if (state !== 4'd15 || halt !== 1'b1) begin bad++; $display("[TB] FAIL badop_error: got st=%0d halt=%0d expected 15 1", state, halt); end
    for (int i = 0; i < 3; i++) begin
      step;
      total++; if (state !== 4'd15 || halt !== 1'b1 || irWrite !== 1'b0 || pcWrite !== 1'b0) begin bad++; $display("[TB] FAIL badop_sticky%0d: got st=%0d halt=%0d ir=%0d pc=%0d expected 15 1 0 0", i, state, halt, irWrite, pcWrite); end
    end
    Rst_n = 1'b0;
    step;
    total++; if (state !== 4'd0) begin bad++; $display("[TB] FAIL badop_reset_state: got %0d expected 0", state); end
    total++; if (halt !== 1'b0) begin bad++; $display("[TB] FAIL badop_reset_halt: got %0d expected 0", halt); end
    Rst_n = 1'b1;
    v = '{'{OP_I,    3'b101, 7'h20, 1'b1, 4'd7},
          '{OP_R,    3'b001, 7'h00, 1'b1, 4'd6},
          '{OP_R,    3'b000, 7'h01, 1'b1, 4'd6},
          '{OP_JALR, 3'b001, 7'h00, 1'b0, 4'd0},
          '{OP_LW,   3'b000, 7'h00, 1'b1, 4'd2}};
    for (int i = 0; i < 5; i++) begin
      resetDut;
      applyStimulus(v[i].op, v[i].f3, v[i].f7, 1'b0, 1'b0, 1'b1);
      step; step;
      if (v[i].hasMid) begin
        total++; if (state !== v[i].mid) begin bad++; $display("[TB] FAIL ill%0d_mid: got %0d expected %0d", i, state, v[i].mid); end
        step;
      end
      total++; if (state !== 4'd15 || halt !== 1'b1 || regWrite !== 1'b0) begin bad++; $display("[TB] FAIL ill%0d_error: got st=%0d halt=%0d rw=%0d expected 15 1 0", i, state, halt, regWrite); end
    end
  endtask

  task automatic test_jumps;
    $display("[TB] test_jumps");
    resetDut;
    applyStimulus(OP_JAL, 3'b000, 7'd0, 1'b0, 1'b0, 1'b1);
    step;
    total++; if (state !== 4'd1 || immSrc !== 3'b011) begin bad++; $display("[TB] FAIL jal_decode: got st=%0d imm=%b expected 1 011", state, immSrc); end
    step;
    total++; if ({state, pcWrite, aluSrcA, aluSrcB, resultSrc} !== {4'd9, 1'b1, 2'b01, 2'b10, 2'b00}) begin bad++; $display("[TB] FAIL jal_state: got %b expected 1001101100", {state, pcWrite, aluSrcA, aluSrcB, resultSrc}); end
    step;
    total++; if (state !== 4'd8 || regWrite !== 1'b1) begin bad++; $display("[TB] FAIL jal_wb: got st=%0d rw=%0d expected 8 1", state, regWrite); end
    step;
    applyStimulus(OP_JALR, 3'b000, 7'd0, 1'b0, 1'b0, 1'b1);
    step;
    total++; if (state !== 4'd1 || immSrc !== 3'b010) begin bad++; $display("[TB] FAIL jalr_decode: got st=%0d imm=%b expected 1 010", state, immSrc); end
    step;
    total++; if ({state, aluSrcA, aluSrcB, immSrc, pcWrite} !== {4'd10, 2'b10, 2'b01, 3'b000, 1'b0}) begin bad++; $display("[TB] FAIL jalr_state: got %b expected 101010010000", {state, aluSrcA, aluSrcB, immSrc, pcWrite}); end
    step;
    total++; if (state !== 4'd9 || pcWrite !== 1'b1) begin bad++; $display("[TB] FAIL jalr_jal: got st=%0d pc=%0d expected 9 1", state, pcWrite); end
    step; step;
    total++; if (state !== 4'd0) begin bad++; $display("[TB] FAIL jalr_latency: got %0d expected 0", state); end
    applyStimulus(OP_LUI, 3'b000, 7'd0, 1'b0, 1'b0, 1'b1);
    step; step;
    total++; if ({state, resultSrc, regWrite, immSrc} !== {4'd12, 2'b11, 1'b1, 3'b100}) begin bad++; $display("[TB] FAIL lui_state: got %b expected 1100111100", {state, resultSrc, regWrite, immSrc}); end
    step;
    total++; if (state !== 4'd0) begin bad++; $display("[TB] FAIL lui_latency: got %0d expected 0", state); end
  endtask

  initial begin
    Rst_n = 1'b0;
    op = 7'd0; func3 = 3'd0; func7 = 7'd0; Zero = 1'b0; Lt = 1'b0; MemReady = 1'b0;
    test_reset;
    test_alu_ops;
    test_branch;
    test_mem_wait;
    test_timeout;
    test_illegal;
    test_jumps;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
